// File: rtl/ibex_tcm_pkg.sv
// Shared types and helpers for the tightly-coupled memory arbiter.
package ibex_tcm_pkg;

  // Up to four request channels, so a two-bit port index is always enough.
  localparam int unsigned MaxPorts = 4;
  localparam int unsigned PortIdxW = 2;

  // Default array geometry; the top recomputes its own width from Depth.
  localparam int unsigned DefaultDepth = 4096;
  localparam int unsigned WordAddrW    = $clog2(DefaultDepth);

  // Metadata that travels down the response pipeline next to the read data.
  typedef struct packed {
    logic                valid;
    logic [PortIdxW-1:0] port;
    logic                err;
    logic                is_write;
  } tcm_rsp_t;

  // Byte offset of an address relative to the array base.
  function automatic logic [31:0] tcm_offset(input logic [31:0] addr,
                                             input logic [31:0] base);
    return addr - base;
  endfunction

  // An address is inside the array when (addr - base) < depth*4, unsigned.
  // Comparing the word part of the offset avoids overflowing depth*4.
  function automatic logic tcm_in_range(input logic [31:0]  addr,
                                        input logic [31:0]  base,
                                        input int unsigned  depth);
    logic [31:0] off;
    off = tcm_offset(addr, base);
    return ({2'b00, off[31:2]} < depth);
  endfunction

endpackage

// File: rtl/tcm_sram_1p.sv
// Behavioural single-port SRAM: byte-enable write, one-cycle registered read.
// Contents are never reset so they survive a core reset.
module tcm_sram_1p
  import ibex_tcm_pkg::*;
#(
  parameter int unsigned Depth = DefaultDepth,
  parameter int unsigned AddrW = WordAddrW
) (
  input  logic             clk_i,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem [Depth];

  // Write only the enabled byte lanes of the addressed word.
  always_ff @(posedge clk_i) begin
    if (req_i && we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // Registered read; the output holds between reads.
  always_ff @(posedge clk_i) begin
    if (req_i && !we_i) begin
      rdata_o <= mem[addr_i];
    end
  end

endmodule

// File: rtl/ibex_tcm_arb.sv
// Shared tightly-coupled memory for several Ibex-style request channels.
//
// Handshake: a port raises req_i with we/be/addr/wdata and holds all of them
// stable until it sees gnt_o high in the same cycle; the access is taken at the
// end of that cycle. Each grant returns exactly one single-cycle rvalid_o pulse
// on that port ReadLatency cycles later, with no back-pressure. The preload
// port has no handshake: a pl_we_i cycle always owns the array.
module ibex_tcm_arb
  import ibex_tcm_pkg::*;
#(
  parameter int unsigned NumPorts    = 2,
  parameter int unsigned Depth       = 4096,
  parameter logic [31:0] BaseAddr    = 32'h0000_0000,
  parameter int unsigned ReadLatency = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumPorts-1:0]      req_i,
  input  logic [NumPorts-1:0]      we_i,
  input  logic [4*NumPorts-1:0]    be_i,
  input  logic [32*NumPorts-1:0]   addr_i,
  input  logic [32*NumPorts-1:0]   wdata_i,
  output logic [NumPorts-1:0]      gnt_o,
  output logic [NumPorts-1:0]      rvalid_o,
  output logic [32*NumPorts-1:0]   rdata_o,
  output logic [NumPorts-1:0]      err_o,
  input  logic                     pl_we_i,
  input  logic [3:0]               pl_be_i,
  input  logic [31:0]              pl_addr_i,
  input  logic [31:0]              pl_wdata_i
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PortW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam logic [PortW-1:0] LastInit = PortW'(NumPorts - 1);

  // ---------------------------------------------------------------------------
  // Round-robin arbiter
  // ---------------------------------------------------------------------------
  logic [PortW-1:0]    last_q;
  logic [PortW-1:0]    sel;
  logic [PortW-1:0]    cand_idx;
  int unsigned         cand;
  logic                any_gnt;

  // Search from last+1 (mod NumPorts); preload and reset block every grant.
  always_comb begin
    sel      = '0;
    any_gnt  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    if (!rst_i && !pl_we_i) begin
      for (int unsigned i = 0; i < NumPorts; i++) begin
        cand = 32'(last_q) + 32'd1 + i;
        if (cand >= NumPorts) begin
          cand = cand - NumPorts;
        end
        cand_idx = PortW'(cand);
        if (!any_gnt && req_i[cand_idx]) begin
          any_gnt = 1'b1;
          sel     = cand_idx;
        end
      end
    end
  end

  assign gnt_o = any_gnt ? (NumPorts'(1) << sel) : '0;

  // Remember the most recently granted port; idle cycles leave it alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= LastInit;
    end else if (any_gnt) begin
      last_q <= sel;
    end
  end

  // ---------------------------------------------------------------------------
  // Array access mux
  // ---------------------------------------------------------------------------
  logic [31:0]      g_addr;
  logic [31:0]      g_wdata;
  logic [3:0]       g_be;
  logic             g_we;
  logic             g_in_range;
  logic             pl_in_range;
  logic [31:0]      g_off;
  logic [31:0]      pl_off;

  logic             mem_req;
  logic             mem_we;
  logic [3:0]       mem_be;
  logic [AddrW-1:0] mem_addr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  // Pick the granted port's payload, or the preload when it owns the cycle.
  always_comb begin
    g_addr      = addr_i[sel*32 +: 32];
    g_wdata     = wdata_i[sel*32 +: 32];
    g_be        = be_i[sel*4 +: 4];
    g_we        = we_i[sel];
    g_in_range  = tcm_in_range(g_addr, BaseAddr, Depth);
    pl_in_range = tcm_in_range(pl_addr_i, BaseAddr, Depth);
    g_off       = tcm_offset(g_addr, BaseAddr);
    pl_off      = tcm_offset(pl_addr_i, BaseAddr);

    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (pl_we_i) begin
      // Out-of-range preloads simply never reach the array.
      mem_req   = pl_in_range;
      mem_we    = 1'b1;
      mem_be    = pl_be_i;
      mem_addr  = pl_off[2 +: AddrW];
      mem_wdata = pl_wdata_i;
    end else begin
      // Out-of-range grants still respond, but never touch the array.
      mem_req   = any_gnt && g_in_range;
      mem_we    = g_we;
      mem_be    = g_be;
      mem_addr  = g_off[2 +: AddrW];
      mem_wdata = g_wdata;
    end
  end

  tcm_sram_1p #(
    .Depth (Depth),
    .AddrW (AddrW)
  ) u_sram (
    .clk_i   (clk_i),
    .req_i   (mem_req),
    .we_i    (mem_we),
    .be_i    (mem_be),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  // ---------------------------------------------------------------------------
  // Response pipeline
  // ---------------------------------------------------------------------------
  tcm_rsp_t rsp_in;
  tcm_rsp_t rsp_q [ReadLatency];
  tcm_rsp_t rsp_out;
  logic [31:0] pipe_rdata;
  logic [31:0] rsp_data;

  always_comb begin
    rsp_in          = '0;
    rsp_in.valid    = any_gnt;
    rsp_in.port     = PortIdxW'(sel);
    rsp_in.err      = !g_in_range;
    rsp_in.is_write = g_we;
  end

  // Shift grant metadata; reset drops everything still in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < ReadLatency; k++) begin
        rsp_q[k] <= '0;
      end
    end else begin
      rsp_q[0] <= rsp_in;
      for (int k = 1; k < ReadLatency; k++) begin
        rsp_q[k] <= rsp_q[k-1];
      end
    end
  end

  // The SRAM supplies the first read stage; extra stages follow the metadata.
  if (ReadLatency > 1) begin : g_rd_pipe
    logic [31:0] rd_q [ReadLatency-1];
    // Data stages need no reset: the metadata valid bit qualifies them.
    always_ff @(posedge clk_i) begin
      rd_q[0] <= mem_rdata;
      for (int k = 1; k < ReadLatency - 1; k++) begin
        rd_q[k] <= rd_q[k-1];
      end
    end
    assign pipe_rdata = rd_q[ReadLatency-2];
  end else begin : g_rd_direct
    assign pipe_rdata = mem_rdata;
  end

  assign rsp_out  = rsp_q[ReadLatency-1];
  assign rsp_data = (rsp_out.err || rsp_out.is_write) ? 32'h0 : pipe_rdata;

  // ---------------------------------------------------------------------------
  // Per-port outputs with hold registers
  // ---------------------------------------------------------------------------
  logic [NumPorts-1:0] rsp_hit;
  logic [31:0]         hold_data_q [NumPorts];
  logic [NumPorts-1:0] hold_err_q;

  // Route the pipeline head to its port; other ports replay their last value.
  always_comb begin
    rsp_hit  = '0;
    rvalid_o = '0;
    rdata_o  = '0;
    err_o    = '0;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      rsp_hit[p] = rsp_out.valid && (rsp_out.port == PortIdxW'(p)) && !rst_i;
      if (!rst_i) begin
        rvalid_o[p]       = rsp_hit[p];
        rdata_o[p*32 +: 32] = rsp_hit[p] ? rsp_data : hold_data_q[p];
        err_o[p]          = rsp_hit[p] ? rsp_out.err : hold_err_q[p];
      end
    end
  end

  // Capture each delivered response so rdata/err stay put between pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int p = 0; p < NumPorts; p++) begin
        hold_data_q[p] <= '0;
      end
      hold_err_q <= '0;
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        if (rsp_hit[p]) begin
          hold_data_q[p] <= rsp_data;
          hold_err_q[p]  <= rsp_out.err;
        end
      end
    end
  end

endmodule

// File: tb/tb_ibex_tcm_arb.sv
// Self-checking bench for ibex_tcm_arb: a queue-based model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_ibex_tcm_arb;

  localparam int          NP    = 2;
  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          LAT   = 2;
  // Expected-response entry: {due cycle[31:0], port[1:0], err, data[31:0]}
  localparam int          W     = 67;

  // ---------------- clock / reset ----------------
  logic              clk   = 1'b0;
  logic              rst_i = 1'b1;
  logic [NP-1:0]     req_i;
  logic [NP-1:0]     we_i;
  logic [4*NP-1:0]   be_i;
  logic [32*NP-1:0]  addr_i;
  logic [32*NP-1:0]  wdata_i;
  logic [NP-1:0]     gnt_o;
  logic [NP-1:0]     rvalid_o;
  logic [32*NP-1:0]  rdata_o;
  logic [NP-1:0]     err_o;
  logic              pl_we_i;
  logic [3:0]        pl_be_i;
  logic [31:0]       pl_addr_i;
  logic [31:0]       pl_wdata_i;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ibex_tcm_arb #(
    .NumPorts    (NP),
    .Depth       (DEPTH),
    .BaseAddr    (BASE),
    .ReadLatency (LAT)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .we_i       (we_i),
    .be_i       (be_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .gnt_o      (gnt_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .err_o      (err_o),
    .pl_we_i    (pl_we_i),
    .pl_be_i    (pl_be_i),
    .pl_addr_i  (pl_addr_i),
    .pl_wdata_i (pl_wdata_i)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  logic [31:0]  m_mem [DEPTH];
  int           m_last = NP - 1;
  logic [31:0]  m_hold_d [NP];
  logic         m_hold_e [NP];
  logic [W-1:0] exp_q [$];

  function automatic bit m_in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < 32'(DEPTH * 4);
  endfunction

  function automatic int m_index(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off >> 2);
  endfunction

  // Compare DUT against the model mid-cycle, then advance the model as the
  // coming rising edge will.
  always @(negedge clk) begin
    logic [NP-1:0]    e_gnt;
    logic [NP-1:0]    e_rv;
    logic [NP-1:0]    e_err;
    logic [32*NP-1:0] e_rd;
    logic [W-1:0]     ent;
    logic [31:0]      a;
    logic [31:0]      d;
    logic [31:0]      wd;
    logic [3:0]       be;
    int               gp;
    int               pp;
    int               idx;
    bit               inr;
    e_gnt = '0;
    e_rv  = '0;
    gp    = -1;
    if (rst_i) begin
      exp_q.delete();
      m_last = NP - 1;
      for (int p = 0; p < NP; p++) begin
        m_hold_d[p] = '0;
        m_hold_e[p] = 1'b0;
      end
      chk("model_rst_gnt", 64'(gnt_o), 64'd0);
      chk("model_rst_rvalid", 64'(rvalid_o), 64'd0);
      chk("model_rst_rdata", 64'(rdata_o), 64'd0);
      chk("model_rst_err", 64'(err_o), 64'd0);
    end else begin
      if (exp_q.size() > 0 && int'(exp_q[0][66:35]) == cyc) begin
        ent = exp_q.pop_front();
        pp  = int'(ent[34:33]);
        e_rv[pp]     = 1'b1;
        m_hold_e[pp] = ent[32];
        m_hold_d[pp] = ent[31:0];
      end
      for (int p = 0; p < NP; p++) begin
        e_rd[32*p +: 32] = m_hold_d[p];
        e_err[p]         = m_hold_e[p];
      end
      chk("model_rvalid", 64'(rvalid_o), 64'(e_rv));
      chk("model_rdata", 64'(rdata_o), 64'(e_rd));
      chk("model_err", 64'(err_o), 64'(e_err));

      if (!pl_we_i) begin
        for (int i = 0; i < NP; i++) begin
          pp = (m_last + 1 + i) % NP;
          if (gp < 0 && req_i[pp]) gp = pp;
        end
      end
      if (gp >= 0) e_gnt[gp] = 1'b1;
      chk("model_gnt", 64'(gnt_o), 64'(e_gnt));

      if (pl_we_i) begin
        if (m_in_range(pl_addr_i)) begin
          idx = m_index(pl_addr_i);
          for (int b = 0; b < 4; b++)
            if (pl_be_i[b]) m_mem[idx][8*b +: 8] = pl_wdata_i[8*b +: 8];
        end
      end else if (gp >= 0) begin
        a   = addr_i[32*gp +: 32];
        wd  = wdata_i[32*gp +: 32];
        be  = be_i[4*gp +: 4];
        inr = m_in_range(a);
        d   = '0;
        if (inr) begin
          idx = m_index(a);
          if (we_i[gp]) begin
            for (int b = 0; b < 4; b++)
              if (be[b]) m_mem[idx][8*b +: 8] = wd[8*b +: 8];
          end else begin
            d = m_mem[idx];
          end
        end
        exp_q.push_back({32'(cyc + LAT), 2'(gp), ~inr, d});
        m_last = gp;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    pl_we_i    = 1'b1;
    pl_addr_i  = a;
    pl_wdata_i = d;
    pl_be_i    = be;
    step();
    pl_we_i    = 1'b0;
  endtask

  // Hold a request until granted; returns just after the grant edge.
  task automatic access(input int p, input logic we, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] wd, output int gcyc);
    bit got;
    got  = 1'b0;
    gcyc = -1;
    req_i[p]          = 1'b1;
    we_i[p]           = we;
    be_i[4*p +: 4]    = be;
    addr_i[32*p +: 32]  = a;
    wdata_i[32*p +: 32] = wd;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (gnt_o[p] === 1'b1) begin
        got  = 1'b1;
        gcyc = cyc;
      end
    end
    chk("grant_seen", 64'(got), 64'd1);
    step();
    req_i[p] = 1'b0;
  endtask

  // Wait (bounded) for the response pulse on a port; realigns to posedge+1.
  task automatic wait_rsp(input int p, output logic [31:0] d, output logic e, output int rcyc);
    bit got;
    got  = 1'b0;
    d    = '0;
    e    = 1'b0;
    rcyc = -1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (rvalid_o[p] === 1'b1) begin
        got  = 1'b1;
        d    = rdata_o[32*p +: 32];
        e    = err_o[p];
        rcyc = cyc;
      end
    end
    chk("response_seen", 64'(got), 64'd1);
    step();
  endtask

  task automatic read_chk(input string name, input int p, input logic [31:0] a,
                          input logic [31:0] exp_d, input logic exp_e);
    int g;
    int r;
    logic [31:0] d;
    logic e;
    access(p, 1'b0, 4'h0, a, 32'h0, g);
    wait_rsp(p, d, e, r);
    chk({name, "_data"}, 64'(d), 64'(exp_d));
    chk({name, "_err"}, 64'(e), 64'(exp_e));
  endtask

  // ---------------- directed stimulus ----------------
  logic [NP-1:0] rr_exp [4];
  logic [31:0]   rr_data [4];

  initial begin
    int g;
    int r;
    logic [31:0] d;
    logic e;
    rr_exp  = '{2'b01, 2'b10, 2'b01, 2'b10};
    rr_data = '{32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0000, 32'hC0DE_0001};

    rst_i = 1'b1;
    req_i = '0; we_i = '0; be_i = '0; addr_i = '0; wdata_i = '0;
    pl_we_i = 1'b0; pl_be_i = '0; pl_addr_i = '0; pl_wdata_i = '0;
    // Requests during reset must not be granted.
    req_i  = 2'b11;
    addr_i = {BASE + 32'h4, BASE};
    repeat (3) step();
    chk("reset_gnt", 64'(gnt_o), 64'd0);
    chk("reset_rvalid", 64'(rvalid_o), 64'd0);
    chk("reset_rdata", 64'(rdata_o), 64'd0);
    chk("reset_err", 64'(err_o), 64'd0);
    req_i = '0;
    rst_i = 1'b0;

    // Fill the first 16 words, then the basic preload/read case.
    for (int k = 0; k < 16; k++) preload(BASE + 32'(4 * k), 32'hC0DE_0000 | 32'(k), 4'hF);
    preload(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
    access(1, 1'b0, 4'hF, BASE + 32'h10, 32'h0, g);
    wait_rsp(1, d, e, r);
    chk("basic_data", 64'(d), 64'hDEAD_BEEF);
    chk("basic_err", 64'(e), 64'd0);
    chk("basic_latency", 64'(r - g), 64'd2);

    // Round-robin straight out of reset: port 0 first, then alternate.
    rst_i = 1'b1;
    step();
    rst_i  = 1'b0;
    we_i   = '0;
    addr_i = {BASE + 32'h4, BASE};
    req_i  = 2'b11;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 4) chk("rr_gnt", 64'(gnt_o), 64'(rr_exp[i]));
      if (i >= 2) begin
        chk("rr_rvalid", 64'(rvalid_o), 64'(rr_exp[i-2]));
        chk("rr_rdata", 64'(rdata_o[32*(i % 2) +: 32]), 64'(rr_data[i-2]));
      end
      if (i == 3) begin
        @(posedge clk);
        #1;
        req_i = '0;
      end
    end
    step();

    // Byte-enable merge; the write itself answers with zero data.
    preload(BASE + 32'h20, 32'hAAAA_AAAA, 4'hF);
    access(0, 1'b1, 4'b0101, BASE + 32'h20, 32'h1122_3344, g);
    wait_rsp(0, d, e, r);
    chk("write_rsp_data", 64'(d), 64'd0);
    chk("write_rsp_err", 64'(e), 64'd0);
    read_chk("be_merge", 0, BASE + 32'h20, 32'hAA22_AA44, 1'b0);
    read_chk("low_bits_ignored", 1, BASE + 32'h13, 32'hDEAD_BEEF, 1'b0);

    // Range boundaries.
    preload(BASE + 32'(DEPTH * 4 - 4), 32'h7777_0001, 4'hF);
    read_chk("last_word", 0, BASE + 32'(DEPTH * 4 - 4), 32'h7777_0001, 1'b0);
    read_chk("one_past_end", 1, BASE + 32'(DEPTH * 4), 32'h0, 1'b1);
    read_chk("below_base", 0, BASE - 32'h4, 32'h0, 1'b1);
    access(1, 1'b1, 4'hF, BASE + 32'(DEPTH * 4), 32'hFFFF_FFFF, g);
    wait_rsp(1, d, e, r);
    chk("oor_write_err", 64'(e), 64'd1);
    chk("oor_write_data", 64'(d), 64'd0);
    read_chk("oor_write_no_effect", 0, BASE, 32'hC0DE_0000, 1'b0);
    preload(BASE + 32'(DEPTH * 4), 32'h1234_5678, 4'hF);
    read_chk("oor_preload_dropped", 0, BASE, 32'hC0DE_0000, 1'b0);

    // Preload priority: three blocked cycles, grant on the fourth.
    req_i[0] = 1'b1;
    we_i[0]  = 1'b0;
    addr_i[31:0] = BASE + 32'h8;
    pl_we_i    = 1'b1;
    pl_be_i    = 4'hF;
    pl_addr_i  = BASE + 32'h40;
    pl_wdata_i = 32'h5000_0040;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("pl_blocks_gnt", 64'(gnt_o), 64'd0);
      @(posedge clk);
      #1;
      if (i < 2) begin
        pl_addr_i  = pl_addr_i + 32'h4;
        pl_wdata_i = pl_wdata_i + 32'h4;
      end else begin
        pl_we_i = 1'b0;
      end
    end
    @(negedge clk);
    chk("pl_then_gnt", 64'(gnt_o), 64'b01);
    @(posedge clk);
    #1;
    req_i[0] = 1'b0;
    wait_rsp(0, d, e, r);
    chk("pl_wait_data", 64'(d), 64'hC0DE_0002);
    read_chk("pl_word_mid", 1, BASE + 32'h44, 32'h5000_0044, 1'b0);

    // Reset one cycle after a read grant: the response must vanish.
    access(0, 1'b0, 4'hF, BASE + 32'h10, 32'h0, g);
    rst_i = 1'b1;
    @(negedge clk);
    chk("midrst_rvalid", 64'(rvalid_o), 64'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_rvalid", 64'(rvalid_o), 64'd0);
      chk("post_rst_rdata", 64'(rdata_o), 64'd0);
      chk("post_rst_err", 64'(err_o), 64'd0);
    end
    step();
    read_chk("contents_survive_reset", 0, BASE + 32'h10, 32'hDEAD_BEEF, 1'b0);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop if the scenario ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
